// File: rtl/i2c_codec_responder.sv
// Purpose: I2C write-only target standing in for the WM8731 control port; decodes {addr+W, reg/d8, d[7:0]} frames into a 9-bit register file.
// Latency: bus events act 3 clk_i2c cycles after the pin change; reg_wr_valid pulses 1 cycle after the SCL fall that ends the third ACK.
// Backpressure: none, SCL is never stretched; bad frames are NACKed (address) or flagged on frame_err. Optional macro: I2C_RESP_SOFT_RESET_EN.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 16
) (
  input  logic       clk_i2c,
  input  logic       reset_n,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [6:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_ACK_A  = 3'd2;
  localparam logic [2:0] S_BYTE1  = 3'd3;
  localparam logic [2:0] S_ACK_1  = 3'd4;
  localparam logic [2:0] S_BYTE2  = 3'd5;
  localparam logic [2:0] S_ACK_2  = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  logic       scl_s1_q, scl_s2_q, scl_prev_q;
  logic       sda_s1_q, sda_s2_q, sda_prev_q;
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] reg_q, reg_d;
  logic       d8_q, d8_d;
  logic [8:0] data_q, data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_vld_q, wr_vld_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic       err_q, err_d;
  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] regs_d [NUM_REGS];

  logic sda_in;
  logic start_ev, stop_ev, scl_rise, scl_fall, in_frame;

  // Open-drain output: only ever pull low or release.
  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in   = I2C_SDAT;

  // Bus conditions decoded from synchronized levels and their previous values.
  assign start_ev = scl_s2_q && scl_prev_q && sda_prev_q && !sda_s2_q;
  assign stop_ev  = scl_s2_q && scl_prev_q && !sda_prev_q && sda_s2_q;
  assign scl_rise = scl_s2_q && !scl_prev_q;
  assign scl_fall = !scl_s2_q && scl_prev_q;
  assign in_frame = (state_q != S_IDLE) && (state_q != S_IGNORE);

  assign busy         = (state_q != S_IDLE);
  assign reg_wr_valid = wr_vld_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign frame_err    = err_q;
  assign rd_data      = (int'(rd_addr) < NUM_REGS) ? regs_q[rd_addr[AW-1:0]] : 9'd0;

  // Frame FSM: START/STOP take priority over any SCL edge seen in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    reg_d     = reg_q;
    d8_d      = d8_q;
    data_d    = data_q;
    sda_oe_d  = sda_oe_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    regs_d    = regs_q;
    if (start_ev) begin
      err_d    = in_frame;
      state_d  = S_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_ev) begin
      err_d    = in_frame;
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_s2_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b1;
            if (state_q == S_ADDR) begin
              if (shift_q == {DEV_ADDR, 1'b0}) begin
                state_d = S_ACK_A;
              end else begin
                state_d  = S_IGNORE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == S_BYTE1) begin
              reg_d   = shift_q[7:1];
              d8_d    = shift_q[0];
              state_d = S_ACK_1;
            end else begin
              data_d  = {d8_q, shift_q};
              state_d = S_ACK_2;
            end
          end
        end
        S_ACK_A, S_ACK_1: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = (state_q == S_ACK_A) ? S_BYTE1 : S_BYTE2;
          end
        end
        S_ACK_2: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_IGNORE;
            if (int'(reg_q) < NUM_REGS) begin
              wr_vld_d  = 1'b1;
              wr_addr_d = reg_q;
              wr_data_d = data_q;
              regs_d[reg_q[AW-1:0]] = data_q;
`ifdef I2C_RESP_SOFT_RESET_EN
              // Register 0x0F acts as the codec's reset register.
              if (reg_q == 7'h0F) begin
                for (int i = 0; i < NUM_REGS; i++) regs_d[i] = 9'd0;
              end
`endif
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Synchronizers idle high (bus released) so reset never fabricates an edge.
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= I2C_SCLK;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  // FSM, datapath and register-file state.
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'd0;
      reg_q     <= 7'd0;
      d8_q      <= 1'b0;
      data_q    <= 9'd0;
      sda_oe_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 9'd0;
      err_q     <= 1'b0;
      regs_q    <= '{default: 9'd0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      reg_q     <= reg_d;
      d8_q      <= d8_d;
      data_q    <= data_d;
      sda_oe_q  <= sda_oe_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      regs_q    <= regs_d;
    end
  end

endmodule
